tmds_ddr_serializer: RTL and testbench
======================================

# tmds_ddr_serializer

Upstream feeder for the HDMI DDR output stage. Accepts 10-bit TMDS symbols (one per data channel) through a valid/ready handshake and buffers them in a 2-entry FIFO. Each symbol is split into five bit-pairs, one pair per `clk`, presented as posedge/negedge data for the DDIO output stage. A fixed TMDS clock-channel pattern is generated alongside, and an idle control symbol is substituted when the FIFO runs dry.

## Interface
- `NCH`, 3, number of TMDS data channels
- `IDLE_SYM`, 10'b1101010100, symbol inserted on underflow (control period, C1C0=00)
- `clk`  in  1  serial clock, 5× pixel rate; all logic on posedge
- `aclr`  in  1  asynchronous active-low reset
- `sym_in`  in  10*NCH  channel k symbol in bits [10k+9:10k]
- `sym_valid`  in  1  `sym_in` valid
- `sym_ready`  out  1  block can accept a symbol this cycle
- `en`  in  1  serializer enable
- `dout_h`  out  NCH+1  posedge bits; bit NCH is the clock channel
- `dout_l`  out  NCH+1  negedge bits; bit NCH is the clock channel
- `dout_oe`  out  1  output enable for the DDIO stage
- `phase`  out  3  current bit-pair index, 0..4
- `underflow`  out  1  one-cycle pulse when `IDLE_SYM` is substituted
- `underflow_cnt`  out  16  saturating underflow count

## Operation
- FIFO: 2 entries of 10*NCH bits.
  - `sym_ready` = (count < 2). It is combinational from count only and never depends on `sym_valid`.
  - Push occurs when `sym_valid & sym_ready`.
  - Push and pop in the same cycle are both legal. When count==2, the push is refused (`sym_ready`=0) even if a pop occurs in that cycle.
- Phase counter:
  - When `en`=1, counts 0,1,2,3,4,0,...
  - When `en`=0, held at 0.
- Symbol load, in a cycle with `phase`==0 and `en`=1:
  - FIFO non-empty: pop the head into the shift register S.
  - FIFO empty: load S with `IDLE_SYM` replicated on all channels, pulse `underflow`, and increment `underflow_cnt`. The count saturates at 16'hFFFF.
- Bit order is LSB first. In phase p, channel k drives `dout_h[k]`=S_k[2p] and `dout_l[k]`=S_k[2p+1].
  - For p=0, S is the symbol loaded in that same cycle.
- Clock channel, bit NCH, follows the fixed pattern 10'b0000011111 with the same ordering:
  - `dout_h`/`dout_l` per phase 0..4: 1/1, 1/1, 1/0, 0/0, 0/0.
- Disable (`en`=0):
  - `dout_h`, `dout_l`, `dout_oe` and `phase` return to 0 on the next edge.
  - A partially sent symbol is discarded, not resent.
  - FIFO contents are retained, and pushes are still accepted.
  - No underflow is counted while disabled.
- Reset (`aclr`=0), effective immediately and asynchronously:
  - FIFO emptied; `sym_ready`=1 once `aclr` is high.
  - `phase`=0, S=0.
  - `dout_h`, `dout_l`, `dout_oe`, `underflow` and `underflow_cnt` all 0.

## Timing
- All outputs except `sym_ready` are registered.
- Bit-pair latency: pair p of a symbol appears on `dout_h`/`dout_l` one `clk` after the cycle in which `phase`==p.
- `dout_oe` is `en` delayed one `clk`, so it is aligned with the first valid bit-pair.
- After `en` rises:
  - The first load happens in the same cycle, since `phase` is 0.
  - The first bits appear on the next edge.
- Throughput: one symbol per 5 `clk`. Sustained streaming requires one push per 5 cycles.
- Push-to-output latency:
  - FIFO empty, push in the cycle before phase 0: minimum 2 `clk` to the first bits.
  - Push in a phase-0 cycle: the symbol waits for the next load, 5 cycles later, because the pop in that cycle sees only the pre-push contents.
- `underflow` is high for exactly the cycle after the substitution load. It aligns with pair 0 of `IDLE_SYM` on the outputs.

## Test plan
- Reset mid-stream:
  - Stimulus: assert `aclr` low while streaming at phase 3.
  - Response: all outputs 0 immediately; after release, `sym_ready`=1 and `phase`=0.
- Single symbol:
  - Stimulus: `en`=1; push ch0=10'h2AA, ch1=10'h155, ch2=10'h3FF.
  - Response, next five cycles: ch0 `dout_h`/`dout_l`=0/1 each cycle; ch1=1/0; ch2=1/1; clock channel follows the 1/1, 1/1, 1/0, 0/0, 0/0 pattern.
- Backpressure:
  - Stimulus: hold `sym_valid`=1 with incrementing symbols and `en`=0.
  - Response: exactly 2 accepted, then `sym_ready`=0.
  - Then raise `en`: one symbol is accepted per 5 cycles, in order, with no loss.
- Underflow:
  - Stimulus: `en`=1 with no pushes for 20 cycles.
  - Response: 4 `IDLE_SYM` symbols on all data channels, 4 `underflow` pulses, `underflow_cnt`=4.
- Disable mid-symbol:
  - Stimulus: drop `en` at phase 2.
  - Response: next edge gives `dout_oe`=0, outputs 0, `phase`=0.
  - On re-enable, the next FIFO symbol starts at pair 0.
- Saturation:
  - Stimulus: force 65 540 underflows.
  - Response: `underflow_cnt` holds at 16'hFFFF; `underflow` keeps pulsing.

Source files
------------

// File: rtl/tmds_ddr_serializer.sv
// TMDS DDR serializer: 2-entry symbol FIFO, 5-phase bit-pair splitter,
// fixed clock-channel pattern and idle-symbol substitution on underflow.

// One output lane: picks bit pair {2p+1, 2p} of a 10-bit symbol and registers it.
module tmds_ddr_lane (
    input  logic       i_clk,
    input  logic       i_aclr,
    input  logic       i_en,
    input  logic [9:0] i_sym,
    input  logic [2:0] i_phase,
    output logic       o_h,
    output logic       o_l
);
    // Phase only ever reaches 4, so both indices stay inside 0..9.
    logic [3:0] w_idx_h;
    logic [3:0] w_idx_l;

    assign w_idx_h = {i_phase, 1'b0};
    assign w_idx_l = {i_phase, 1'b1};

    // Register the selected pair; a disabled lane drives zeros.
    always_ff @(posedge i_clk or negedge i_aclr) begin
        if (!i_aclr) begin
            o_h <= 1'b0;
            o_l <= 1'b0;
        end else begin
            o_h <= i_en & i_sym[w_idx_h];
            o_l <= i_en & i_sym[w_idx_l];
        end
    end
endmodule

module tmds_ddr_serializer #(
    parameter int         NCH      = 3,
    parameter logic [9:0] IDLE_SYM = 10'b1101010100
) (
    input  logic              i_clk,
    input  logic              i_aclr,
    input  logic [10*NCH-1:0] i_sym_in,
    input  logic              i_sym_valid,
    output logic              o_sym_ready,
    input  logic              i_en,
    output logic [NCH:0]      o_dout_h,
    output logic [NCH:0]      o_dout_l,
    output logic              o_dout_oe,
    output logic [2:0]        o_phase,
    output logic              o_underflow,
    output logic [15:0]       o_underflow_cnt
);
    localparam int         W       = 10 * NCH;
    localparam logic [9:0] CLK_PAT = 10'b0000011111;

    logic [W-1:0]  r_mem [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_cnt;
    logic [W-1:0]  r_shift;
    logic [2:0]    r_phase;
    logic          r_oe;
    logic          r_underflow;
    logic [15:0]   r_ucnt;

    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic          w_subst;
    logic [W-1:0]  w_sym;

    // Ready depends on occupancy only: a full FIFO refuses even if it pops this cycle.
    assign o_sym_ready = (r_cnt < 2'd2);
    assign w_empty     = (r_cnt == 2'd0);
    assign w_push      = i_sym_valid & o_sym_ready;
    assign w_load      = i_en & (r_phase == 3'd0);
    // The load sees only pre-push contents, so a push in a load cycle waits a symbol.
    assign w_pop       = w_load & ~w_empty;
    assign w_subst     = w_load & w_empty;

    // Symbol feeding the lanes: freshly loaded in phase 0, else the held one.
    assign w_sym = !w_load ? r_shift :
                   w_empty ? {NCH{IDLE_SYM}} : r_mem[r_rptr];

    // FIFO storage needs no reset; occupancy tracking decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_sym_in;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_aclr) begin
        if (!i_aclr) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Phase counter 0..4 while enabled, parked at 0 otherwise.
    always_ff @(posedge i_clk or negedge i_aclr) begin
        if (!i_aclr)                r_phase <= 3'd0;
        else if (!i_en)             r_phase <= 3'd0;
        else if (r_phase == 3'd4)   r_phase <= 3'd0;
        else                        r_phase <= r_phase + 3'd1;
    end

    // Hold the loaded symbol for phases 1..4.
    always_ff @(posedge i_clk or negedge i_aclr) begin
        if (!i_aclr)     r_shift <= '0;
        else if (w_load) r_shift <= w_sym;
    end

    // Output enable trails en by one cycle, underflow pulse and saturating count.
    always_ff @(posedge i_clk or negedge i_aclr) begin
        if (!i_aclr) begin
            r_oe        <= 1'b0;
            r_underflow <= 1'b0;
            r_ucnt      <= 16'd0;
        end else begin
            r_oe        <= i_en;
            r_underflow <= w_subst;
            if (w_subst && r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 16'd1;
        end
    end

    // Data lanes plus the clock lane, which serializes a constant pattern.
    generate
        for (genvar k = 0; k < NCH; k++) begin : g_lane
            tmds_ddr_lane u_lane (
                .i_clk   (i_clk),
                .i_aclr  (i_aclr),
                .i_en    (i_en),
                .i_sym   (w_sym[10*k +: 10]),
                .i_phase (r_phase),
                .o_h     (o_dout_h[k]),
                .o_l     (o_dout_l[k])
            );
        end
    endgenerate

    tmds_ddr_lane u_clk_lane (
        .i_clk   (i_clk),
        .i_aclr  (i_aclr),
        .i_en    (i_en),
        .i_sym   (CLK_PAT),
        .i_phase (r_phase),
        .o_h     (o_dout_h[NCH]),
        .o_l     (o_dout_l[NCH])
    );

    assign o_phase         = r_phase;
    assign o_dout_oe       = r_oe;
    assign o_underflow     = r_underflow;
    assign o_underflow_cnt = r_ucnt;
endmodule

// File: tb/tb_tmds_ddr_serializer.sv
// Directed bench for tmds_ddr_serializer (NCH=3).
module tb_tmds_ddr_serializer;
    localparam logic [9:0]  IDLE  = 10'b1101010100;
    localparam logic [29:0] IDLE3 = {IDLE, IDLE, IDLE};

    logic        clk;
    logic        aclr;
    logic [29:0] sym_in;
    logic        sym_valid;
    logic        sym_ready;
    logic        en;
    logic [3:0]  dout_h;
    logic [3:0]  dout_l;
    logic        dout_oe;
    logic [2:0]  phase;
    logic        underflow;
    logic [15:0] underflow_cnt;

    int n_chk = 0;
    int n_err = 0;

    tmds_ddr_serializer #(.NCH(3), .IDLE_SYM(IDLE)) dut (
        .i_clk           (clk),
        .i_aclr          (aclr),
        .i_sym_in        (sym_in),
        .i_sym_valid     (sym_valid),
        .o_sym_ready     (sym_ready),
        .i_en            (en),
        .o_dout_h        (dout_h),
        .o_dout_l        (dout_l),
        .o_dout_oe       (dout_oe),
        .o_phase         (phase),
        .o_underflow     (underflow),
        .o_underflow_cnt (underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [29:0] mk(input int i);
        return {10'(10'h300 + i), 10'(10'h200 + i), 10'(10'h100 + i)};
    endfunction

    // Expected pair p of symbol s on data lanes; clock lane from the fixed table.
    task automatic check_pair(input string tag, input logic [29:0] s, input int p);
        logic [3:0] eh;
        logic [3:0] el;
        logic [4:0] ckh;
        logic [4:0] ckl;
        ckh = 5'b00111;
        ckl = 5'b00011;
        for (int k = 0; k < 3; k++) begin
            eh[k] = s[10*k + 2*p];
            el[k] = s[10*k + 2*p + 1];
        end
        eh[3] = ckh[p];
        el[3] = ckl[p];
        chk({tag, "_h"}, 32'(dout_h), 32'(eh));
        chk({tag, "_l"}, 32'(dout_l), 32'(el));
    endtask

    initial begin
        int idx;
        int acc;
        int nuf;
        int npulse;
        logic rdy;
        logic [29:0] rb;
        logic [4:0] ckh;
        logic [4:0] ckl;
        logic [15:0] sat_exp [5];
        ckh = 5'b00111;
        ckl = 5'b00011;
        rb  = '0;

        aclr = 1'b0; en = 1'b0; sym_valid = 1'b0; sym_in = '0;
        #3;
        chk("rst_h", 32'(dout_h), 0);
        chk("rst_l", 32'(dout_l), 0);
        chk("rst_oe", 32'(dout_oe), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_uf", 32'(underflow), 0);
        chk("rst_ucnt", 32'(underflow_cnt), 0);
        chk("rst_ready", 32'(sym_ready), 1);
        #9 aclr = 1'b1;
        tick;

        // Single symbol: ch0=2AA ch1=155 ch2=3FF
        sym_in = {10'h3FF, 10'h155, 10'h2AA};
        sym_valid = 1'b1;
        tick;
        sym_valid = 1'b0;
        en = 1'b1;
        for (int p = 0; p < 5; p++) begin
            tick;
            chk("single_h", 32'(dout_h), 32'({ckh[p], 3'b110}));
            chk("single_l", 32'(dout_l), 32'({ckl[p], 3'b101}));
            chk("single_uf", 32'(underflow), 0);
            chk("single_oe", 32'(dout_oe), 1);
        end
        en = 1'b0;
        tick;
        chk("off_h", 32'(dout_h), 0);
        chk("off_l", 32'(dout_l), 0);
        chk("off_oe", 32'(dout_oe), 0);
        chk("off_uf", 32'(underflow), 0);
        chk("off_ucnt", 32'(underflow_cnt), 0);

        // Underflow: 20 cycles with nothing pushed
        en = 1'b1;
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (underflow) npulse++;
            if (i < 5) check_pair("idle", IDLE3, i);
        end
        chk("uf_pulses", 32'(npulse), 4);
        chk("uf_cnt", 32'(underflow_cnt), 4);
        chk("uf_phase", 32'(phase), 0);
        en = 1'b0;
        tick;

        // Backpressure with en=0: two accepted then ready drops
        idx = 0;
        sym_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sym_in = mk(idx);
            rdy = sym_ready;
            chk("bp_ready", 32'(rdy), (i < 2) ? 1 : 0);
            tick;
            if (rdy) idx++;
        end
        chk("bp_accepted", 32'(idx), 2);

        // Enable: one accept per symbol, output stream in order
        en = 1'b1;
        acc = 0;
        nuf = 0;
        for (int e = 0; e < 25; e++) begin
            sym_in = mk(idx);
            rdy = sym_ready;
            tick;
            if (rdy) begin idx++; acc++; end
            if (underflow) nuf++;
            for (int k = 0; k < 3; k++) begin
                rb[10*k + 2*(e%5)]     = dout_h[k];
                rb[10*k + 2*(e%5) + 1] = dout_l[k];
            end
            if (e % 5 == 4) chk("stream_sym", 32'(rb), 32'(mk(e/5)));
        end
        sym_valid = 1'b0;
        chk("stream_acc", 32'(acc), 5);
        chk("stream_nuf", 32'(nuf), 0);

        // Disable mid-symbol: mk(5) is cut at phase 2, mk(6) starts clean
        tick;
        check_pair("pre0", mk(5), 0);
        tick;
        check_pair("pre1", mk(5), 1);
        chk("pre_phase", 32'(phase), 2);
        en = 1'b0;
        tick;
        chk("dis_h", 32'(dout_h), 0);
        chk("dis_l", 32'(dout_l), 0);
        chk("dis_oe", 32'(dout_oe), 0);
        chk("dis_phase", 32'(phase), 0);
        en = 1'b1;
        for (int p = 0; p < 5; p++) begin
            tick;
            check_pair("resume", mk(6), p);
        end

        // Push in a phase-0 cycle: idle goes out, the symbol waits one slot
        sym_in = mk(9);
        sym_valid = 1'b1;
        tick;
        sym_valid = 1'b0;
        chk("p0push_uf", 32'(underflow), 1);
        check_pair("p0push_idle", IDLE3, 0);
        chk("p0push_ucnt", 32'(underflow_cnt), 5);
        for (int p = 1; p < 5; p++) tick;
        tick;
        chk("late_uf", 32'(underflow), 0);
        check_pair("late", mk(9), 0);
        en = 1'b0;
        tick;

        // Minimum latency: push during phase 4 with an empty FIFO
        en = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        chk("minlat_phase", 32'(phase), 4);
        sym_in = mk(11);
        sym_valid = 1'b1;
        tick;
        sym_valid = 1'b0;
        tick;
        check_pair("minlat", mk(11), 0);
        chk("minlat_uf", 32'(underflow), 0);
        chk("minlat_ucnt", 32'(underflow_cnt), 6);

        // Reset mid-stream at phase 3
        tick;
        tick;
        chk("mid_phase", 32'(phase), 3);
        #2 aclr = 1'b0;
        #1;
        chk("arst_h", 32'(dout_h), 0);
        chk("arst_l", 32'(dout_l), 0);
        chk("arst_oe", 32'(dout_oe), 0);
        chk("arst_phase", 32'(phase), 0);
        chk("arst_uf", 32'(underflow), 0);
        chk("arst_ucnt", 32'(underflow_cnt), 0);
        en = 1'b0;
        #10 aclr = 1'b1;
        #1;
        chk("arst_ready", 32'(sym_ready), 1);
        chk("arst_phase2", 32'(phase), 0);

        // Saturation: preload near the top, then keep underflowing
        tick;
        force dut.r_ucnt = 16'hFFFD;
        #1 release dut.r_ucnt;
        sat_exp[0] = 16'hFFFE;
        sat_exp[1] = 16'hFFFF;
        sat_exp[2] = 16'hFFFF;
        sat_exp[3] = 16'hFFFF;
        sat_exp[4] = 16'hFFFF;
        en = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick;
            chk("sat_uf", 32'(underflow), 1);
            chk("sat_cnt", 32'(underflow_cnt), 32'(sat_exp[j]));
            for (int p = 1; p < 5; p++) tick;
        end
        en = 1'b0;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
